// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          w_clk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          wr_req,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          wr_count
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  typedef enum logic {ARB, BURST} state_t;
  state_t               state_q;
  logic [GW-1:0]        grant_q, last_q, win_d, idx;
  logic [BW-1:0]        bcnt_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 any_d, xfer;
  always_comb begin
    win_d = '0;
    any_d = 1'b0;
    idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = GW'((int'(last_q) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        win_d = idx;
        any_d = 1'b1;
      end
    end
  end
  assign busy      = state_q == BURST;
  assign grant_id  = grant_q;
  assign wr_count  = cnt_q;
  assign xfer      = busy && req_valid[grant_q] && !fifo_full;
  assign wr_req    = xfer;
  assign req_ready = (busy && !fifo_full) ? NUM_REQ'(1) << grant_q : '0;
  assign data_in   = busy ? req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
  always_ff @(posedge w_clk) begin
    if (!wrst) begin
      state_q <= ARB;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ - 1);
      bcnt_q  <= '0;
      cnt_q   <= '0;
    end else if (state_q == ARB) begin
      if (any_d) begin
        grant_q <= win_d;
        bcnt_q  <= '0;
        state_q <= BURST;
      end
    end else if (xfer) begin
      cnt_q <= cnt_q + 1'b1;
      if (bcnt_q == BW'(MAX_BURST - 1)) begin
        last_q  <= grant_q;
        state_q <= ARB;
      end else begin
        bcnt_q <= bcnt_q + 1'b1;
      end
    end else if (!fifo_full) begin
      last_q  <= grant_q;
      state_q <= ARB;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed checks of grant order, bursts, stalls, release, reset and counter wrap
module tb_fifo_wr_arbiter;
  logic        w_clk = 1'b0;
  logic        wrst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        wr_req;
  logic [7:0]  data_in;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] wr_count;
  logic [1:0]  v2;
  logic [15:0] d2;
  logic [1:0]  rdy2;
  logic        wr2, busy2;
  logic [7:0]  din2, cnt2;
  logic        gnt2;
  int passed = 0;
  int total = 0;
  always #5 w_clk = ~w_clk;
  fifo_wr_arbiter dut (
    .w_clk(w_clk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .wr_req(wr_req), .data_in(data_in),
    .grant_id(grant_id), .busy(busy), .wr_count(wr_count)
  );
  fifo_wr_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .MAX_BURST(16), .CNT_WIDTH(8)) dut_wrap (
    .w_clk(w_clk), .wrst(wrst), .req_valid(v2), .req_data(d2),
    .req_ready(rdy2), .fifo_full(1'b0), .wr_req(wr2), .data_in(din2),
    .grant_id(gnt2), .busy(busy2), .wr_count(cnt2)
  );
  task automatic tick;
    @(posedge w_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic do_reset;
    wrst = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    v2 = '0;
    tick;
    tick;
    wrst = 1'b1;
  endtask
  initial begin
    req_data = '0;
    d2 = 16'h5A5A;
    do_reset;
    chk("rst_busy", busy, 0);
    chk("rst_count", wr_count, 0);
    chk("rst_wr_req", wr_req, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_data", data_in, 0);
    chk("rst_grant", grant_id, 0);
    req_valid = 4'b0001;
    tick;
    chk("t1_busy", busy, 1);
    chk("t1_grant", grant_id, 0);
    for (int b = 0; b < 4; b++) begin
      req_data[7:0] = 8'(8'h10 + b);
      #1;
      chk("t1_wr_req", wr_req, 1);
      chk("t1_data", data_in, 32'(8'h10 + b));
      tick;
    end
    chk("t1_dead_busy", busy, 0);
    chk("t1_count", wr_count, 4);
    chk("t1_dead_wr", wr_req, 0);
    tick;
    chk("t1_regrant_busy", busy, 1);
    chk("t1_regrant_id", grant_id, 0);
    do_reset;
    req_data = 32'hA3A2A1A0;
    req_valid = 4'b1111;
    for (int n = 1; n <= 21; n++) begin
      tick;
      chk("t2_busy", busy, (n % 5 != 0) ? 1 : 0);
      chk("t2_wr_req", wr_req, (n % 5 != 0) ? 1 : 0);
      if (n % 5 != 0) begin
        chk("t2_grant", grant_id, ((n - 1) / 5) % 4);
        chk("t2_data", data_in, 8'hA0 + ((n - 1) / 5) % 4);
      end
    end
    chk("t2_count", wr_count, 16);
    do_reset;
    req_data = 32'h00C20000;
    req_valid = 4'b0100;
    tick;
    chk("t3_busy", busy, 1);
    chk("t3_grant", grant_id, 2);
    chk("t3_ready", req_ready, 4'b0100);
    chk("t3_wr_req", wr_req, 1);
    chk("t3_data", data_in, 8'hC2);
    tick;
    tick;
    chk("t3_count2", wr_count, 2);
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) req_valid = 4'b0000;
      #1;
      chk("t3_stall_wr", wr_req, 0);
      chk("t3_stall_ready", req_ready, 0);
      chk("t3_stall_grant", grant_id, 2);
      chk("t3_stall_busy", busy, 1);
      tick;
    end
    chk("t3_hold_count", wr_count, 2);
    req_valid = 4'b0100;
    fifo_full = 1'b0;
    #1;
    chk("t3_resume_busy", busy, 1);
    chk("t3_resume_wr", wr_req, 1);
    tick;
    chk("t3_busy3", busy, 1);
    chk("t3_count3", wr_count, 3);
    tick;
    chk("t3_end_busy", busy, 0);
    chk("t3_count4", wr_count, 4);
    do_reset;
    req_valid = 4'b0010;
    tick;
    chk("t4_busy", busy, 1);
    chk("t4_grant1", grant_id, 1);
    req_valid = 4'b1010;
    tick;
    chk("t4_keep_busy", busy, 1);
    chk("t4_keep_grant", grant_id, 1);
    chk("t4_count", wr_count, 1);
    req_valid = 4'b1001;
    tick;
    chk("t4_release", busy, 0);
    tick;
    chk("t4_busy3", busy, 1);
    chk("t4_grant3", grant_id, 3);
    do_reset;
    req_valid = 4'b1111;
    tick;
    tick;
    tick;
    chk("t5_count2", wr_count, 2);
    chk("t5_busy", busy, 1);
    wrst = 1'b0;
    tick;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_count", wr_count, 0);
    chk("t5_rst_wr", wr_req, 0);
    chk("t5_rst_ready", req_ready, 0);
    wrst = 1'b1;
    tick;
    chk("t5_regrant_busy", busy, 1);
    chk("t5_regrant_id", grant_id, 0);
    do_reset;
    v2 = 2'b01;
    begin
      bit hit = 0;
      for (int i = 0; i < 400 && !hit; i++) begin
        tick;
        if (cnt2 == 8'hFF) hit = 1;
      end
      chk("t6_reach_ff", hit, 1);
    end
    chk("t6_pending_wr", wr2, 1);
    chk("t6_busy", busy2, 1);
    tick;
    chk("t6_wrap", cnt2, 0);
    chk("t6_grant", gnt2, 0);
    chk("t6_burst_end", busy2, 0);
    chk("t6_main_idle", wr_count, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter for the asynchronous FIFO. Shares the FIFO write side (wr_req, data_in, fifo_full) among NUM_REQ producers in the write clock domain.
- Grants one producer at a time for a bounded burst of up to MAX_BURST writes. Stalls on fifo_full. Keeps a free-running count of accepted writes for debug and coverage.

Parameters:
- NUM_REQ, 4, number of requesting producers (2..8)
- DATA_WIDTH, 8, FIFO data width
- MAX_BURST, 4, maximum writes per grant (1..16)
- CNT_WIDTH, 16, width of wr_count

Ports:
- w_clk  input  1  write-domain clock; the only clock
- wrst  input  1  synchronous, active-low reset
- req_valid  input  NUM_REQ  per-producer "data available"
- req_data  input  NUM_REQ*DATA_WIDTH  producer i data at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  output  NUM_REQ  per-producer accept; a beat transfers when req_valid[i] && req_ready[i]
- fifo_full  input  1  FIFO full flag, write domain
- wr_req  output  1  FIFO write strobe
- data_in  output  DATA_WIDTH  FIFO write data
- grant_id  output  $clog2(NUM_REQ)  current owner index; valid while busy=1
- busy  output  1  burst in progress (state BURST)
- wr_count  output  CNT_WIDTH  total accepted writes, wraps

Behaviour:
- All state updates on posedge w_clk. Reset applies when wrst==0 at a clock edge.
- Reset values: state=ARB, grant_id=0, last_grant=NUM_REQ-1 (so producer 0 wins first), burst_cnt=0, wr_count=0, busy=0. Combinational outputs evaluate to wr_req=0, req_ready=0, data_in=0.
- FSM state ARB:
  - If no req_valid bit is set, stay in ARB.
  - Otherwise pick the first set bit scanning from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Register the winner into grant_id, clear burst_cnt, go to BURST.
  - No transfer occurs in ARB: one dead cycle per arbitration.
- FSM state BURST, combinational outputs:
  - req_ready[grant_id] = !fifo_full; all other req_ready bits = 0.
  - wr_req = req_valid[grant_id] && !fifo_full.
  - data_in = req_data slice for grant_id when busy=1, otherwise 0.
  - The FIFO write and the producer handshake are the same event.
- BURST per-cycle rules (evaluated in this order):
  - Transfer (wr_req=1): wr_count += 1, wrapping at 2^CNT_WIDTH. If burst_cnt==MAX_BURST-1, set last_grant=grant_id and go to ARB. Else burst_cnt += 1.
  - fifo_full=1: stall. No transfer, burst_cnt holds, state holds. A stall never ends a burst and never changes the owner.
  - req_valid[grant_id]==0 and fifo_full==0: the owner released early. Set last_grant=grant_id and go to ARB.
- Simultaneous events:
  - Requests arriving for other producers during BURST are ignored until ARB.
  - A producer dropping req_valid in the same cycle fifo_full=1 is a stall, not a release; release is taken on the first non-full cycle with valid low.
- Fairness: a continuously requesting producer waits at most (NUM_REQ-1) bursts plus stall cycles.
- Reset mid-burst: burst aborted, state returns to ARB, the in-flight beat is not written, wr_count clears.
- fifo_full is consumed as-is. The FIFO must assert full in the same write-domain cycle the last free slot is used. The arbiter adds no lookahead.

Test Plan:
- Reset, then req_valid=4'b0001, data 0x10..0x13, fifo empty -> ARB cycle, then 4 consecutive wr_req with data_in 0x10,0x11,0x12,0x13. wr_count=4. Back to ARB. Producer 0 re-granted after one dead cycle.
- All req_valid=4'b1111 held for 20 cycles -> grant order 0,1,2,3,0. Each burst is 4 writes. busy low exactly one cycle between bursts. wr_count=16 after 4 bursts.
- Producer 2 granted, fifo_full forced high for 5 cycles after its 2nd write -> req_ready=0, wr_req=0 for 5 cycles. grant_id stays 2. Remaining 2 writes complete after full drops; burst total is 4.
- Producer 1 granted, drops req_valid after 1 write while producer 3 requesting -> return to ARB. Producer 3 granted next, with last_grant=1.
- wrst pulled low for one cycle mid-burst with req_valid=4'b1111 -> next cycle busy=0, wr_count=0, wr_req=0. Next grant goes to producer 0.
- Preload wr_count to 0xFFFF via 65535 writes, then one more write -> wr_count=0x0000, no other side effects.
